// File: rtl/operand_loader_pkg.sv
// Shared types and defaults for the operand loader.
package operand_loader_pkg;

    localparam int OPLOAD_DEF_WIDTH   = 4;
    localparam int OPLOAD_DEF_TIMEOUT = 8;

    typedef enum logic [2:0] {
        ST_A,
        ST_B,
        ST_C,
        ST_S,
        ST_OUT
    } opload_state_e;

endpackage

// File: rtl/operand_loader_if.sv
// Beat input / operand output bundle for operand_loader.
// master = upstream+downstream environment, slave = the loader itself.
interface operand_loader_if #(
    parameter int WIDTH = operand_loader_pkg::OPLOAD_DEF_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_c;
    logic             op_s;
    logic             op_valid;
    logic             op_ack;
    logic             err;

    modport master (
        output in_valid, in_data, op_ack,
        input  in_ready, op_a, op_b, op_c, op_s, op_valid, err
    );

    modport slave (
        input  in_valid, in_data, op_ack,
        output in_ready, op_a, op_b, op_c, op_s, op_valid, err
    );
endinterface

// File: rtl/operand_loader.sv
// Collects four beats (A, B, C, S) into one stable operand frame for the mux/adder stage.
// Define OPLOAD_TIMEOUT_EN to drop partial frames after TIMEOUT idle cycles (err pulse).
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH   = OPLOAD_DEF_WIDTH,
    parameter int TIMEOUT = OPLOAD_DEF_TIMEOUT
) (
    input logic               clk,
    input logic               rst_n,
    operand_loader_if.slave   bus
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("operand_loader: TIMEOUT must be at least 1");
    end

    opload_state_e    state;
    logic [WIDTH-1:0] stg_a, stg_b, stg_c;
    logic [WIDTH-1:0] op_a, op_b, op_c;
    logic             op_s, op_valid, in_ready, err;
    logic             acc;

    assign acc = bus.in_valid && in_ready;

`ifdef OPLOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             mid_frame;

    assign mid_frame = (state == ST_B) || (state == ST_C) || (state == ST_S);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_A;
            stg_a    <= '0;
            stg_b    <= '0;
            stg_c    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_c     <= '0;
            op_s     <= 1'b0;
            op_valid <= 1'b0;
            in_ready <= 1'b1;
            err      <= 1'b0;
`ifdef OPLOAD_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                ST_A: if (acc) begin
                    stg_a <= bus.in_data;
                    state <= ST_B;
                end
                ST_B: if (acc) begin
                    stg_b <= bus.in_data;
                    state <= ST_C;
                end
                ST_C: if (acc) begin
                    stg_c <= bus.in_data;
                    state <= ST_S;
                end
                ST_S: if (acc) begin
                    // whole frame publishes on one edge so downstream never sees a mix
                    op_a     <= stg_a;
                    op_b     <= stg_b;
                    op_c     <= stg_c;
                    op_s     <= bus.in_data[0];
                    op_valid <= 1'b1;
                    in_ready <= 1'b0;
                    state    <= ST_OUT;
                end
                ST_OUT: if (bus.op_ack) begin
                    op_valid <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= ST_A;
                end
                default: begin
                    state    <= ST_A;
                    op_valid <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
`ifdef OPLOAD_TIMEOUT_EN
            // an accepted beat always beats the timeout on the same edge
            if (!mid_frame || acc) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                cnt   <= '0;
                state <= ST_A;
                stg_a <= '0;
                stg_b <= '0;
                stg_c <= '0;
                err   <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
`endif
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.op_a     = op_a;
    assign bus.op_b     = op_b;
    assign bus.op_c     = op_c;
    assign bus.op_s     = op_s;
    assign bus.op_valid = op_valid;
`ifdef OPLOAD_TIMEOUT_EN
    assign bus.err      = err;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader; timeout cases run only with OPLOAD_TIMEOUT_EN.
module tb_operand_loader;
    import operand_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    operand_loader_if #(.WIDTH(4)) bus ();

    operand_loader #(.WIDTH(4), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_ops(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic s);
        chk({tag, "_a"}, 8'(bus.op_a), 8'(a));
        chk({tag, "_b"}, 8'(bus.op_b), 8'(b));
        chk({tag, "_c"}, 8'(bus.op_c), 8'(c));
        chk({tag, "_s"}, 8'(bus.op_s), 8'(s));
    endtask

    task automatic ack();
        bus.op_ack = 1'b1;
        step();
        bus.op_ack = 1'b0;
    endtask

    initial begin
        logic [3:0] fr [4];
        int         errs;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.op_ack   = 1'b0;

        // reset state
        step();
        chk("rst_valid", 8'(bus.op_valid), 8'd0);
        chk("rst_ready", 8'(bus.in_ready), 8'd1);
        chk("rst_err", 8'(bus.err), 8'd0);
        chk_ops("rst", 4'd0, 4'd0, 4'd0, 1'b0);
        rst_n = 1'b1;
        step();

        // frame 3,5,9,1 with in_valid held
        bus.in_valid = 1'b1;
        fr = '{4'd3, 4'd5, 4'd9, 4'd1};
        for (int i = 0; i < 3; i++) begin
            bus.in_data = fr[i];
            step();
        end
        chk("f1_valid_early", 8'(bus.op_valid), 8'd0);
        chk_ops("f1_early", 4'd0, 4'd0, 4'd0, 1'b0);
        bus.in_data = fr[3];
        step();
        chk("f1_valid", 8'(bus.op_valid), 8'd1);
        chk("f1_ready", 8'(bus.in_ready), 8'd0);
        chk_ops("f1", 4'd3, 4'd5, 4'd9, 1'b1);

        // hold in ST_OUT with in_valid/F asserted
        bus.in_data = 4'hF;
        for (int i = 0; i < 10; i++) step();
        chk("hold_valid", 8'(bus.op_valid), 8'd1);
        chk("hold_ready", 8'(bus.in_ready), 8'd0);
        chk_ops("hold", 4'd3, 4'd5, 4'd9, 1'b1);
        bus.in_valid = 1'b0;
        ack();
        chk("ack_valid", 8'(bus.op_valid), 8'd0);
        chk("ack_ready", 8'(bus.in_ready), 8'd1);
        chk_ops("retain", 4'd3, 4'd5, 4'd9, 1'b1);

        // frame 2,4,6,0 with 3-cycle gaps
        errs = 0;
        fr = '{4'd2, 4'd4, 4'd6, 4'd0};
        for (int i = 0; i < 4; i++) begin
            beat(fr[i]);
            if (bus.err) errs++;
            if (i < 3) begin
                for (int j = 0; j < 3; j++) begin
                    step();
                    if (bus.err) errs++;
                end
            end
        end
        chk("gap_valid", 8'(bus.op_valid), 8'd1);
        chk("gap_err", 8'(errs), 8'd0);
        chk_ops("gap", 4'd2, 4'd4, 4'd6, 1'b0);
        ack();

        // op_ack pulsed in ST_B is ignored
        beat(4'd9);
        ack();
        chk("ackb_valid", 8'(bus.op_valid), 8'd0);
        beat(4'd10);
        beat(4'd11);
        chk("ackb_valid_mid", 8'(bus.op_valid), 8'd0);
        beat(4'd1);
        chk("ackb_valid_end", 8'(bus.op_valid), 8'd1);
        chk_ops("ackb", 4'd9, 4'd10, 4'd11, 1'b1);

        // bubble: beat offered on the ack edge is not taken
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd7;
        ack();
        bus.in_valid = 1'b0;
        beat(4'd5);
        beat(4'd6);

        // reset mid-frame
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 8'(bus.op_valid), 8'd0);
        chk("mrst_ready", 8'(bus.in_ready), 8'd1);
        chk_ops("mrst", 4'd0, 4'd0, 4'd0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        beat(4'd1);
        beat(4'd1);
        beat(4'd1);
        beat(4'd0);
        chk("post_valid", 8'(bus.op_valid), 8'd1);
        chk_ops("post", 4'd1, 4'd1, 4'd1, 1'b0);
        ack();

`ifdef OPLOAD_TIMEOUT_EN
        // 8 idle cycles after beats 7,8 drop the partial frame
        beat(4'd7);
        beat(4'd8);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.err) errs++;
        end
        chk("to_err_cnt", 8'(errs), 8'd1);
        chk("to_valid", 8'(bus.op_valid), 8'd0);
        chk_ops("to_keep", 4'd1, 4'd1, 4'd1, 1'b0);
        beat(4'd1);
        beat(4'd2);
        beat(4'd3);
        beat(4'd1);
        chk("to_next_valid", 8'(bus.op_valid), 8'd1);
        chk_ops("to_next", 4'd1, 4'd2, 4'd3, 1'b1);
        ack();

        // beat on the would-be timeout edge wins
        errs = 0;
        beat(4'd5);
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus.err) errs++;
        end
        beat(4'd6);
        if (bus.err) errs++;
        beat(4'd7);
        beat(4'd1);
        chk("edge_err", 8'(errs), 8'd0);
        chk("edge_valid", 8'(bus.op_valid), 8'd1);
        chk_ops("edge", 4'd5, 4'd6, 4'd7, 1'b1);
        ack();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits for A/B/C and the input bus.
REQ-002 Parameter TIMEOUT, default 8, idle cycles tolerated between beats of one frame (used only with OPLOAD_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_data  input  WIDTH  beat payload.
REQ-007 in_ready  output  1  loader accepts a beat this cycle.
REQ-008 op_a, op_b, op_c  output  WIDTH each  operands for the downstream mux/adder stage.
REQ-009 op_s  output  1  mux select for the downstream stage.
REQ-010 op_valid  output  1  op_* hold a complete, stable frame.
REQ-011 op_ack  input  1  downstream consumed the frame.
REQ-012 err  output  1  one-cycle pulse: partial frame dropped by timeout.

Function
REQ-013 A frame SHALL be four accepted beats, in order A, B, C, S; S = in_data[0], in_data[WIDTH-1:1] ignored.
REQ-014 A beat SHALL be accepted only when in_valid && in_ready at the rising edge.
REQ-015 The FSM SHALL use states ST_A, ST_B, ST_C, ST_S, ST_OUT; each accepted beat advances ST_A->ST_B->ST_C->ST_S->ST_OUT.
REQ-016 in_ready SHALL be 1 in ST_A..ST_S and 0 in ST_OUT.
REQ-017 Beats SHALL be captured into staging registers; op_a/op_b/op_c/op_s SHALL update only on the ST_S->ST_OUT transition, all in the same edge.
REQ-018 op_valid SHALL be 1 exactly while in ST_OUT, rising the cycle after the S beat is accepted (latency 1 from last beat).
REQ-019 In ST_OUT, op_* SHALL stay constant until op_ack is sampled high; then FSM SHALL go to ST_A and op_valid SHALL drop next cycle.
REQ-020 op_* SHALL retain the last frame after op_valid drops, until the next frame completes.
REQ-021 op_ack while not in ST_OUT SHALL be ignored.
REQ-022 in_valid while in ST_OUT SHALL be ignored (not accepted, no state change); back-to-back frames cost one bubble cycle minimum.
REQ-023 in_data SHALL be stored unmodified; no arithmetic is performed in this block.

Reset
REQ-024 On rst_n low, immediately: state ST_A, op_a=op_b=op_c=0, op_s=0, op_valid=0, err=0, staging registers 0, timeout counter 0.
REQ-025 Reset mid-frame or in ST_OUT SHALL discard the frame; in_ready SHALL be 1 after reset release (state ST_A).

Configuration
REQ-026 With OPLOAD_TIMEOUT_EN defined: in ST_B, ST_C or ST_S, a counter SHALL count cycles without an accepted beat and clear on each accepted beat.
REQ-027 With OPLOAD_TIMEOUT_EN, when the counter reaches TIMEOUT, FSM SHALL return to ST_A, clear staging and counter, pulse err for exactly one cycle; op_* and op_valid unaffected.
REQ-028 A beat accepted on the same edge the counter would reach TIMEOUT SHALL win (beat accepted, no timeout).
REQ-029 Without OPLOAD_TIMEOUT_EN: no counter is built, the FSM waits indefinitely in ST_B..ST_S, err SHALL be constant 0.

Structure
REQ-030 Package operand_loader_pkg SHALL hold the state enum type (ST_A..ST_OUT) and constants OPLOAD_DEF_WIDTH=4, OPLOAD_DEF_TIMEOUT=8.
REQ-031 No sub-module; a single module with one FSM, staging registers and optional timeout counter.

Verification
REQ-032 Reset, then beats 3,5,9,1 with in_valid held -> op_valid=1 one cycle after 4th beat; op_a=3, op_b=5, op_c=9, op_s=1; in_ready=0.
REQ-033 Hold op_ack=0 for 10 cycles while driving in_valid=1, in_data=F -> op_* unchanged, no beat accepted; then op_ack=1 -> op_valid=0 next cycle, in_ready=1.
REQ-034 Frame 2,4,6,0 with in_valid gaps of 3 cycles between beats (macro off) -> op_a=2, op_b=4, op_c=6, op_s=0; err never 1.
REQ-035 Macro on, TIMEOUT=8: beats 7,8 then 8 idle cycles -> err pulses once, state ST_A; next frame 1,2,3,1 -> op_a=1 (not 7).
REQ-036 Assert rst_n=0 after beats A=5,B=6 -> op_valid=0, all op_*=0 immediately; after release, frame A,B,C,S=1,1,1,0 -> op_a=op_b=op_c=1, op_s=0.
REQ-037 op_ack pulsed while in ST_B -> no effect; frame completes normally.
